// File: rtl/if_stage_if.sv
// Fetch-stage bundle: ID-stage redirect/stall controls, the ROM address/data pair and the IF/ID register outputs.
interface if_stage_if #(
    parameter int PC_WIDTH = 5
);
    logic                stall;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                jump;
    logic [PC_WIDTH-1:0] jump_target;
    logic [31:0]         inst_in;
    logic [PC_WIDTH-1:0] pc_out;
    logic [31:0]         if_id_inst;
    logic [PC_WIDTH-1:0] if_id_pc_plus1;
    logic                if_id_valid;

    // The pipeline/ROM side drives controls and the fetched word.
    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, inst_in,
        input  pc_out, if_id_inst, if_id_pc_plus1, if_id_valid
    );

    // The fetch stage consumes controls and produces the PC and IF/ID contents.
    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, inst_in,
        output pc_out, if_id_inst, if_id_pc_plus1, if_id_valid
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register plus IF/ID pipeline register, with load-use stall
// and ID-resolved branch/jump redirects that flush the slot fetched in the redirect cycle.
module if_stage #(
    parameter int                  PC_WIDTH = 5,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst,
    if_stage_if.slave bus
);
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_ONE;
    endfunction

    logic [PC_WIDTH-1:0] pc_p0;
    logic [31:0]         inst_p1;
    logic [PC_WIDTH-1:0] pc_plus1_p1;
    logic                vld_p1;

    logic [PC_WIDTH-1:0] pc_nxt;
    logic [31:0]         inst_nxt;
    logic [PC_WIDTH-1:0] pc_plus1_nxt;
    logic                vld_nxt;

    // A stalled ID instruction's operands are not final, so stall masks any redirect.
    always_comb begin
        pc_nxt       = pc_inc(pc_p0);
        inst_nxt     = bus.inst_in;
        pc_plus1_nxt = pc_inc(pc_p0);
        vld_nxt      = 1'b1;
        if (bus.stall) begin
            pc_nxt       = pc_p0;
            inst_nxt     = inst_p1;
            pc_plus1_nxt = pc_plus1_p1;
            vld_nxt      = vld_p1;
        end else if (bus.jump || bus.branch_taken) begin
            pc_nxt       = bus.jump ? bus.jump_target : bus.branch_target;
            inst_nxt     = '0;
            pc_plus1_nxt = '0;
            vld_nxt      = 1'b0;
        end
    end

    // p0 -> p1: PC advances while the word it addressed is latched into IF/ID
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0       <= RESET_PC;
            inst_p1     <= '0;
            pc_plus1_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            pc_p0       <= pc_nxt;
            inst_p1     <= inst_nxt;
            pc_plus1_p1 <= pc_plus1_nxt;
            vld_p1      <= vld_nxt;
        end
    end

    assign bus.pc_out         = pc_p0;
    assign bus.if_id_inst     = inst_p1;
    assign bus.if_id_pc_plus1 = pc_plus1_p1;
    assign bus.if_id_valid    = vld_p1;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, free-run, stall, branch, jump priority, stall-masked jump, wrap, mid-run reset.
module tb_if_stage;
    localparam int PCW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    logic [31:0] rom [32];

    if_stage_if #(.PC_WIDTH(PCW)) bus ();

    if_stage #(.PC_WIDTH(PCW), .RESET_PC(5'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb bus.inst_in = rom[bus.pc_out];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [PCW-1:0] target);
        for (int i = 0; i < 64 && bus.pc_out !== target; i++) step();
        check("reach_pc", 32'(bus.pc_out), 32'(target));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"},  32'(bus.pc_out), 32'h0);
        check({tag, "_ins"}, bus.if_id_inst, 32'h0);
        check({tag, "_p1"},  32'(bus.if_id_pc_plus1), 32'h0);
        check({tag, "_vld"}, 32'(bus.if_id_valid), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h2000_0000 | 32'(i);
        rom[1]  = 32'h0043_0820;
        rom[4]  = 32'h8C24_0002;
        rom[5]  = 32'h0081_2823;
        rom[11] = 32'h0800_0009;

        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        bus.jump = 1'b0;  bus.jump_target = '0;

        step(); step();
        check_reset("rst");

        rst = 1'b0;
        step();
        check("first_pc",  32'(bus.pc_out), 32'h01);
        check("first_ins", bus.if_id_inst, rom[0]);
        check("first_p1",  32'(bus.if_id_pc_plus1), 32'h01);
        check("first_vld", 32'(bus.if_id_valid), 32'h1);
        step();
        check("run2_pc",  32'(bus.pc_out), 32'h02);
        check("run2_ins", bus.if_id_inst, 32'h0043_0820);
        check("run2_p1",  32'(bus.if_id_pc_plus1), 32'h02);

        run_to(5'h05);
        check("pre_stall_ins", bus.if_id_inst, 32'h8C24_0002);
        bus.stall = 1'b1;
        step();
        bus.stall = 1'b0;
        check("stall_pc",  32'(bus.pc_out), 32'h05);
        check("stall_ins", bus.if_id_inst, 32'h8C24_0002);
        check("stall_vld", 32'(bus.if_id_valid), 32'h1);
        step();
        check("resume_pc",  32'(bus.pc_out), 32'h06);
        check("resume_ins", bus.if_id_inst, 32'h0081_2823);
        check("resume_p1",  32'(bus.if_id_pc_plus1), 32'h06);

        run_to(5'h0A);
        bus.branch_taken = 1'b1; bus.branch_target = 5'h0B;
        step();
        bus.branch_taken = 1'b0;
        check("br_pc",  32'(bus.pc_out), 32'h0B);
        check("br_ins", bus.if_id_inst, 32'h0);
        check("br_vld", 32'(bus.if_id_valid), 32'h0);
        check("br_p1",  32'(bus.if_id_pc_plus1), 32'h0);
        step();
        check("br_tgt_ins", bus.if_id_inst, 32'h0800_0009);
        check("br_tgt_vld", 32'(bus.if_id_valid), 32'h1);
        check("br_tgt_p1",  32'(bus.if_id_pc_plus1), 32'h0C);

        bus.jump = 1'b1; bus.jump_target = 5'h09;
        bus.branch_taken = 1'b1; bus.branch_target = 5'h0B;
        step();
        bus.jump = 1'b0; bus.branch_taken = 1'b0;
        check("jb_pc",  32'(bus.pc_out), 32'h09);
        check("jb_ins", bus.if_id_inst, 32'h0);
        check("jb_vld", 32'(bus.if_id_valid), 32'h0);
        step();
        check("jb_tgt_ins", bus.if_id_inst, rom[9]);
        check("jb_tgt_pc",  32'(bus.pc_out), 32'h0A);

        run_to(5'h0D);
        bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 5'h09;
        step();
        bus.stall = 1'b0; bus.jump = 1'b0;
        check("sj_pc",  32'(bus.pc_out), 32'h0D);
        check("sj_ins", bus.if_id_inst, rom[12]);
        check("sj_p1",  32'(bus.if_id_pc_plus1), 32'h0D);
        check("sj_vld", 32'(bus.if_id_valid), 32'h1);
        step();
        check("sj_after_pc", 32'(bus.pc_out), 32'h0E);

        run_to(5'h1F);
        step();
        check("wrap_pc",  32'(bus.pc_out), 32'h00);
        check("wrap_p1",  32'(bus.if_id_pc_plus1), 32'h00);
        check("wrap_ins", bus.if_id_inst, rom[31]);

        run_to(5'h03);
        rst = 1'b1; bus.stall = 1'b1;
        step();
        check_reset("midrst");
        rst = 1'b0; bus.stall = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
